mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning max granted cycles without mem_opdone before abort (legal 2..65535).
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports r0_mem_operation / r1_mem_operation  in  2  requester op: 00 none, 01 read, 11 write (10 treated as none).
REQ-005 SHALL have ports r0_addr / r1_addr  in  32  requester word address.
REQ-006 SHALL have ports r0_wdata / r1_wdata  in  32  requester write data.
REQ-007 SHALL have ports r0_rdata / r1_rdata  out  32  read data returned to requester.
REQ-008 SHALL have ports r0_opdone / r1_opdone  out  1  transaction-complete pulse to requester.
REQ-009 SHALL have ports mem_operation  out  2, mem_addr  out  32, mem_wdata  out  32  shared memory request.
REQ-010 SHALL have ports mem_rdata  in  32, mem_opdone  in  1  shared memory response.
REQ-011 SHALL have port grant  out  2  one-hot current owner (bit0 = r0, bit1 = r1), 00 when idle.
REQ-012 SHALL have port timeout  out  1  one-cycle pulse on abort.

Function
REQ-013 SHALL implement states IDLE, GRANT, ABORT plus registers grant_id, last_id, timeout counter (width ceil(log2(TIMEOUT+1))).
REQ-014 IDLE: requester active if op is 01 or 11; one active -> GRANT to it; both active -> GRANT to the one != last_id (round-robin); none -> stay IDLE.
REQ-015 Memory sees a request starting the cycle after the requester first asserts (1-cycle arbitration latency).
REQ-016 In GRANT, mem_operation/mem_addr/mem_wdata SHALL be combinational mux of the granted requester; in IDLE and ABORT mem_operation = 00, mem_addr = 0, mem_wdata = 0.
REQ-017 rN_rdata SHALL equal mem_rdata when N granted in GRANT, else 0.
REQ-018 rN_opdone SHALL equal mem_opdone gated by (state == GRANT and grant_id == N); non-granted requester never sees opdone.
REQ-019 mem_opdone in GRANT -> next state IDLE, last_id <= grant_id; a requester holding its op asserted is re-arbitrated, so it does not starve the other.
REQ-020 Granted requester dropping op to 00 before mem_opdone -> IDLE next edge, last_id unchanged, no opdone issued.
REQ-021 Counter clears on GRANT entry, increments each GRANT cycle without mem_opdone; after TIMEOUT such cycles -> ABORT.
REQ-022 ABORT (one cycle): granted rN_opdone = 1, rN_rdata = 0, timeout = 1, then IDLE with last_id <= grant_id.
REQ-023 mem_opdone in the same cycle the counter expires SHALL win: normal completion, no ABORT.
REQ-024 mem_opdone while IDLE or ABORT SHALL be ignored.
REQ-025 grant SHALL be one-hot of grant_id in GRANT and ABORT, 00 in IDLE.

Reset
REQ-026 reset SHALL force IDLE, grant_id = 0, last_id = 1 (r0 wins first tie), counter = 0, therefore all outputs 0.
REQ-027 reset mid-transaction SHALL drop mem_operation to 00 immediately, with no opdone to either requester.

Structure
REQ-028 Shared package knight_mem_pkg SHALL hold MEM_NONE = 2'b00, MEM_READ = 2'b01, MEM_WRITE = 2'b11 and the arbiter state encoding.
REQ-029 No sub-module; single always block for state plus combinational muxes.

Verification
REQ-030 r0 read addr 0x10, memory opdone 3 cycles later with 0xCAFE0001 -> grant=01 one cycle after request, r0_rdata=0xCAFE0001 with r0_opdone, r1_opdone stays 0.
REQ-031 r0 and r1 both request continuously, memory opdone 1 cycle after each grant -> grants alternate 01,10,01,10; first grant r0 after reset.
REQ-032 r1 write addr 0x20 data 0x12345678, memory never responds, TIMEOUT=4 -> after 4 GRANT cycles one ABORT cycle: r1_opdone=1, r1_rdata=0, timeout=1, then IDLE.
REQ-033 TIMEOUT=4, mem_opdone on 4th GRANT cycle -> normal completion, timeout stays 0.
REQ-034 r0 granted, r0 drops op before opdone -> IDLE next edge, mem_operation=00, no opdone; pending r1 granted next.
REQ-035 reset asserted mid-GRANT -> all outputs 0 asynchronously; after release r0 wins a simultaneous request.

Source files
------------

// File: rtl/knight_mem_pkg.sv
// Shared memory-op encodings and arbiter state encoding for the memory port arbiter.
package knight_mem_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_ABORT = 2'b10
  } arb_state_t;

  // Only read and write are real requests; 2'b10 counts as no request.
  function automatic logic op_active(input logic [1:0] op);
    return (op == MEM_READ) || (op == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the memory port arbiter.
interface mem_port_arbiter_if;
  import knight_mem_pkg::*;

  logic [1:0]  r0_mem_operation;
  logic [1:0]  r1_mem_operation;
  logic [31:0] r0_addr;
  logic [31:0] r1_addr;
  logic [31:0] r0_wdata;
  logic [31:0] r1_wdata;
  logic [31:0] r0_rdata;
  logic [31:0] r1_rdata;
  logic        r0_opdone;
  logic        r1_opdone;
  logic [1:0]  mem_operation;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_opdone;
  logic [1:0]  grant;
  logic        timeout;

  // Arbiter view: takes requests and memory responses, drives everything else.
  modport slave (
    input  r0_mem_operation, r1_mem_operation, r0_addr, r1_addr,
           r0_wdata, r1_wdata, mem_rdata, mem_opdone,
    output r0_rdata, r1_rdata, r0_opdone, r1_opdone,
           mem_operation, mem_addr, mem_wdata, grant, timeout
  );

  // Environment view: requesters and memory model.
  modport master (
    output r0_mem_operation, r1_mem_operation, r0_addr, r1_addr,
           r0_wdata, r1_wdata, mem_rdata, mem_opdone,
    input  r0_rdata, r1_rdata, r0_opdone, r1_opdone,
           mem_operation, mem_addr, mem_wdata, grant, timeout
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port, with a
// per-transaction watchdog that aborts a grant the memory never completes.
module mem_port_arbiter
  import knight_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state, state_nxt;
  logic             grant_id, grant_id_nxt;
  logic             last_id, last_id_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             r0_act, r1_act, own_act;
  logic [1:0]       own_op;

  assign r0_act  = op_active(bus.r0_mem_operation);
  assign r1_act  = op_active(bus.r1_mem_operation);
  assign own_act = grant_id ? r1_act : r0_act;
  assign own_op  = grant_id ? bus.r1_mem_operation : bus.r0_mem_operation;

  // State register; last_id resets to 1 so r0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant_id <= 1'b0;
      last_id  <= 1'b1;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_id_nxt;
      last_id  <= last_id_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Next-state: arbitration in IDLE, completion/drop/watchdog in GRANT.
  // Completion beats both a dropped request and watchdog expiry.
  always_comb begin
    state_nxt    = state;
    grant_id_nxt = grant_id;
    last_id_nxt  = last_id;
    cnt_nxt      = cnt;
    case (state)
      ST_IDLE: begin
        if (r0_act || r1_act) begin
          state_nxt    = ST_GRANT;
          cnt_nxt      = '0;
          grant_id_nxt = (r0_act && r1_act) ? ~last_id : r1_act;
        end
      end
      ST_GRANT: begin
        if (bus.mem_opdone) begin
          state_nxt   = ST_IDLE;
          last_id_nxt = grant_id;
        end else if (!own_act) begin
          state_nxt   = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = ST_ABORT;
        end else begin
          cnt_nxt     = cnt + CNT_W'(1);
        end
      end
      ST_ABORT: begin
        state_nxt   = ST_IDLE;
        last_id_nxt = grant_id;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: memory mux and response routing to the owner only.
  always_comb begin
    bus.mem_operation = MEM_NONE;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.r0_rdata      = '0;
    bus.r1_rdata      = '0;
    bus.r0_opdone     = 1'b0;
    bus.r1_opdone     = 1'b0;
    bus.grant         = 2'b00;
    bus.timeout       = 1'b0;
    case (state)
      ST_GRANT: begin
        bus.mem_operation = own_act ? own_op : MEM_NONE;
        bus.mem_addr      = grant_id ? bus.r1_addr  : bus.r0_addr;
        bus.mem_wdata     = grant_id ? bus.r1_wdata : bus.r0_wdata;
        bus.grant         = grant_id ? 2'b10 : 2'b01;
        if (grant_id) begin
          bus.r1_rdata  = bus.mem_rdata;
          bus.r1_opdone = bus.mem_opdone;
        end else begin
          bus.r0_rdata  = bus.mem_rdata;
          bus.r0_opdone = bus.mem_opdone;
        end
      end
      ST_ABORT: begin
        bus.grant     = grant_id ? 2'b10 : 2'b01;
        bus.timeout   = 1'b1;
        bus.r0_opdone = ~grant_id;
        bus.r1_opdone = grant_id;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT = 4.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   g;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.r0_mem_operation = 2'b00;
    bus.r1_mem_operation = 2'b00;
    bus.r0_addr  = '0;
    bus.r1_addr  = '0;
    bus.r0_wdata = '0;
    bus.r1_wdata = '0;
    bus.mem_rdata  = '0;
    bus.mem_opdone = 1'b0;

    // Reset state
    #2;
    check("rst_grant",     bus.grant,         32'd0);
    check("rst_mem_op",    bus.mem_operation, 32'd0);
    check("rst_mem_addr",  bus.mem_addr,      32'd0);
    check("rst_timeout",   bus.timeout,       32'd0);
    check("rst_r0_opdone", bus.r0_opdone,     32'd0);
    check("rst_r1_opdone", bus.r1_opdone,     32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // r0 read at 0x10, memory completes three cycles after the request
    bus.r0_mem_operation = 2'b01;
    bus.r0_addr          = 32'h10;
    @(negedge clk);
    check("t1_c0_grant",  bus.grant,         32'd0);
    check("t1_c0_mem_op", bus.mem_operation, 32'd0);
    step();
    @(negedge clk);
    check("t1_c1_grant",    bus.grant,         32'd1);
    check("t1_c1_mem_op",   bus.mem_operation, 32'd1);
    check("t1_c1_mem_addr", bus.mem_addr,      32'h10);
    step();
    @(negedge clk);
    check("t1_c2_r0_opdone", bus.r0_opdone, 32'd0);
    step();
    bus.mem_opdone = 1'b1;
    bus.mem_rdata  = 32'hCAFE0001;
    @(negedge clk);
    check("t1_r0_opdone", bus.r0_opdone, 32'd1);
    check("t1_r0_rdata",  bus.r0_rdata,  32'hCAFE0001);
    check("t1_r1_opdone", bus.r1_opdone, 32'd0);
    check("t1_r1_rdata",  bus.r1_rdata,  32'd0);
    step();
    bus.mem_opdone       = 1'b0;
    bus.mem_rdata        = '0;
    bus.r0_mem_operation = 2'b00;
    @(negedge clk);
    check("t1_idle_grant", bus.grant, 32'd0);

    // Both requesters continuous after a fresh reset: grants alternate from r0
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.r0_mem_operation = 2'b01;
    bus.r0_addr          = 32'h100;
    bus.r1_mem_operation = 2'b01;
    bus.r1_addr          = 32'h200;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      @(negedge clk);
      check($sformatf("t2_idle_grant_%0d", k), bus.grant, 32'd0);
      step();
      @(negedge clk);
      check($sformatf("t2_grant_%0d", k), bus.grant, (g == 1) ? 32'd2 : 32'd1);
      check($sformatf("t2_addr_%0d", k), bus.mem_addr, (g == 1) ? 32'h200 : 32'h100);
      step();
      bus.mem_opdone = 1'b1;
      bus.mem_rdata  = 32'hA0000000 + k;
      @(negedge clk);
      check($sformatf("t2_r0_opdone_%0d", k), bus.r0_opdone, (g == 0) ? 32'd1 : 32'd0);
      check($sformatf("t2_r1_opdone_%0d", k), bus.r1_opdone, (g == 1) ? 32'd1 : 32'd0);
      step();
      bus.mem_opdone = 1'b0;
    end
    bus.r0_mem_operation = 2'b00;
    bus.r1_mem_operation = 2'b00;
    step();

    // r1 write that memory never answers: four GRANT cycles then ABORT
    bus.r1_mem_operation = 2'b11;
    bus.r1_addr          = 32'h20;
    bus.r1_wdata         = 32'h12345678;
    bus.mem_rdata        = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      check($sformatf("t3_grant_%0d", k),   bus.grant,         32'd2);
      check($sformatf("t3_mem_op_%0d", k),  bus.mem_operation, 32'd3);
      check($sformatf("t3_wdata_%0d", k),   bus.mem_wdata,     32'h12345678);
      check($sformatf("t3_addr_%0d", k),    bus.mem_addr,      32'h20);
      check($sformatf("t3_timeout_%0d", k), bus.timeout,       32'd0);
    end
    step();
    bus.r1_mem_operation = 2'b00;
    @(negedge clk);
    check("t3_abort_r1_opdone", bus.r1_opdone,     32'd1);
    check("t3_abort_r1_rdata",  bus.r1_rdata,      32'd0);
    check("t3_abort_timeout",   bus.timeout,       32'd1);
    check("t3_abort_grant",     bus.grant,         32'd2);
    check("t3_abort_mem_op",    bus.mem_operation, 32'd0);
    check("t3_abort_r0_opdone", bus.r0_opdone,     32'd0);
    step();
    bus.mem_opdone = 1'b1;
    @(negedge clk);
    check("t3_idle_grant",     bus.grant,     32'd0);
    check("t3_idle_timeout",   bus.timeout,   32'd0);
    check("t3_idle_r0_opdone", bus.r0_opdone, 32'd0);
    check("t3_idle_r1_opdone", bus.r1_opdone, 32'd0);
    step();
    bus.mem_opdone = 1'b0;

    // Completion on the fourth GRANT cycle beats the watchdog
    bus.r0_mem_operation = 2'b01;
    bus.r0_addr          = 32'h40;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      check($sformatf("t4_grant_%0d", k),   bus.grant,   32'd1);
      check($sformatf("t4_timeout_%0d", k), bus.timeout, 32'd0);
    end
    step();
    bus.mem_opdone = 1'b1;
    bus.mem_rdata  = 32'h55AA55AA;
    @(negedge clk);
    check("t4_r0_opdone", bus.r0_opdone, 32'd1);
    check("t4_r0_rdata",  bus.r0_rdata,  32'h55AA55AA);
    check("t4_timeout",   bus.timeout,   32'd0);
    step();
    bus.mem_opdone       = 1'b0;
    bus.r0_mem_operation = 2'b00;
    @(negedge clk);
    check("t4_after_grant",   bus.grant,   32'd0);
    check("t4_after_timeout", bus.timeout, 32'd0);
    step();

    // r0 drops its request mid-grant; pending r1 is served next
    bus.r0_mem_operation = 2'b01;
    bus.r0_addr          = 32'h80;
    step();
    @(negedge clk);
    check("t5_c1_grant", bus.grant, 32'd1);
    step();
    bus.r0_mem_operation = 2'b00;
    bus.r1_mem_operation = 2'b01;
    bus.r1_addr          = 32'h90;
    @(negedge clk);
    check("t5_c2_grant",     bus.grant,         32'd1);
    check("t5_c2_mem_op",    bus.mem_operation, 32'd0);
    check("t5_c2_r0_opdone", bus.r0_opdone,     32'd0);
    step();
    @(negedge clk);
    check("t5_c3_grant",  bus.grant,         32'd0);
    check("t5_c3_mem_op", bus.mem_operation, 32'd0);
    step();
    @(negedge clk);
    check("t5_c4_grant",    bus.grant,         32'd2);
    check("t5_c4_mem_op",   bus.mem_operation, 32'd1);
    check("t5_c4_mem_addr", bus.mem_addr,      32'h90);

    // Asynchronous reset in the middle of r1's grant
    bus.mem_opdone       = 1'b1;
    bus.r0_mem_operation = 2'b01;
    #1 reset = 1'b1;
    #1;
    check("t6_rst_grant",     bus.grant,         32'd0);
    check("t6_rst_mem_op",    bus.mem_operation, 32'd0);
    check("t6_rst_mem_addr",  bus.mem_addr,      32'd0);
    check("t6_rst_r0_opdone", bus.r0_opdone,     32'd0);
    check("t6_rst_r1_opdone", bus.r1_opdone,     32'd0);
    check("t6_rst_timeout",   bus.timeout,       32'd0);
    bus.mem_opdone = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t6_idle_grant", bus.grant, 32'd0);
    step();
    @(negedge clk);
    check("t6_first_grant",    bus.grant,    32'd1);
    check("t6_first_mem_addr", bus.mem_addr, 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
